// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an N x N output-stationary systolic array: skews A-column / B-row
// operands diagonally and generates per-anti-diagonal finish pulses plus a tile-done strobe.
module systolic_skew_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4,
   parameter int K_LEN      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_left,
   input  logic [N*DATA_WIDTH-1:0] in_up,
   input  logic                    flush,
   output logic [N*DATA_WIDTH-1:0] o_left,
   output logic [N*DATA_WIDTH-1:0] o_up,
   output logic [2*N-2:0]          o_finish_diag,
   output logic                    o_tile_done,
   output logic                    o_busy
);

   localparam int NDIAG    = 2*N - 1;
   localparam int DONE_LEN = 2*N;
   localparam int VLD_LEN  = (N > 1) ? N - 1 : 1;
   localparam int KW       = (K_LEN > 1) ? $clog2(K_LEN) : 1;

   logic                    flush_pend_q, flush_pend_d;
   logic                    tile_open_q, tile_open_d;
   logic [KW-1:0]           k_cnt_q, k_cnt_d;
   logic [NDIAG-1:0]        fin_q, fin_d;
   logic [DONE_LEN-1:0]     done_q, done_d;
   logic [VLD_LEN-1:0]      vld_q, vld_d;
   logic                    busy_q, busy_d;

   logic [N*DATA_WIDTH-1:0] item_left_s;
   logic [N*DATA_WIDTH-1:0] item_up_s;
   logic                    item_fin_s;
   logic                    item_vld_s;
   logic                    closing_s;

   assign in_ready = rst_n & ~flush_pend_q;

   // Issue slot: a pending flush beat wins over an offered beat, otherwise a bubble.
   always_comb begin
      item_left_s  = '0;
      item_up_s    = '0;
      item_fin_s   = 1'b0;
      item_vld_s   = 1'b0;
      closing_s    = 1'b0;
      flush_pend_d = flush_pend_q;
      tile_open_d  = tile_open_q;
      k_cnt_d      = k_cnt_q;
      if (flush_pend_q) begin
         item_fin_s   = 1'b1;
         closing_s    = tile_open_q;
         k_cnt_d      = '0;
         flush_pend_d = 1'b0;
         tile_open_d  = 1'b0;
      end else begin
         if (in_valid) begin
            item_left_s = in_left;
            item_up_s   = in_up;
            item_vld_s  = 1'b1;
            item_fin_s  = (k_cnt_q == '0);
            closing_s   = (k_cnt_q == '0) & tile_open_q;
            k_cnt_d     = (k_cnt_q == KW'(K_LEN - 1)) ? '0 : k_cnt_q + 1'b1;
            tile_open_d = 1'b1;
         end else begin
            k_cnt_d = k_cnt_q;
         end
         flush_pend_d = flush;
      end
   end

   // Finish, tile-done and beat-presence shift chains; busy looks at the next state.
   always_comb begin
      fin_d[0] = item_fin_s;
      for (int d = 1; d < NDIAG; d++) begin
         fin_d[d] = fin_q[d-1];
      end
      done_d[0] = closing_s;
      for (int d = 1; d < DONE_LEN; d++) begin
         done_d[d] = done_q[d-1];
      end
      vld_d[0] = item_vld_s;
      for (int s = 1; s < VLD_LEN; s++) begin
         vld_d[s] = vld_q[s-1];
      end
      busy_d = item_vld_s | (|vld_q) | (|fin_d) | (|done_d) | flush_pend_d;
   end

   // Control state and timing chains.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flush_pend_q <= 1'b0;
         tile_open_q  <= 1'b0;
         k_cnt_q      <= '0;
         fin_q        <= '0;
         done_q       <= '0;
         vld_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         flush_pend_q <= flush_pend_d;
         tile_open_q  <= tile_open_d;
         k_cnt_q      <= k_cnt_d;
         fin_q        <= fin_d;
         done_q       <= done_d;
         vld_q        <= vld_d;
         busy_q       <= busy_d;
      end
   end

   assign o_finish_diag = fin_q;
   assign o_tile_done   = done_q[DONE_LEN-1];
   assign o_busy        = busy_q;

   // Lane i carries i+1 register stages so lane i lags lane 0 by exactly i cycles.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] left_q [i+1];
      logic [DATA_WIDTH-1:0] left_d [i+1];
      logic [DATA_WIDTH-1:0] up_q   [i+1];
      logic [DATA_WIDTH-1:0] up_d   [i+1];

      // Shift the lane one stage per cycle.
      always_comb begin
         left_d[0] = item_left_s[i*DATA_WIDTH +: DATA_WIDTH];
         up_d[0]   = item_up_s[i*DATA_WIDTH +: DATA_WIDTH];
         for (int s = 1; s <= i; s++) begin
            left_d[s] = left_q[s-1];
            up_d[s]   = up_q[s-1];
         end
      end

      // Lane stage registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int s = 0; s <= i; s++) begin
               left_q[s] <= '0;
               up_q[s]   <= '0;
            end
         end else begin
            left_q <= left_d;
            up_q   <= up_d;
         end
      end

      assign o_left[i*DATA_WIDTH +: DATA_WIDTH] = left_q[i];
      assign o_up[i*DATA_WIDTH +: DATA_WIDTH]   = up_q[i];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: an absolute-time expectation timeline plus a PE-array
// model fed from the DUT outputs, whose latched tiles are compared with matrix products.
module tb_systolic_skew_feeder;
   localparam int DW   = 8;
   localparam int N    = 4;
   localparam int K    = 4;
   localparam int NL   = N*DW;
   localparam int ND   = 2*N-1;
   localparam int VW   = 2*NL + ND + 2;
   localparam int MAXC = 4096;
   localparam int CW   = N*N*32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [NL-1:0] in_left;
   logic [NL-1:0] in_up;
   logic          flush;
   logic [NL-1:0] o_left;
   logic [NL-1:0] o_up;
   logic [ND-1:0] o_finish_diag;
   logic          o_tile_done;
   logic          o_busy;

   systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K_LEN(K)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_left(in_left), .in_up(in_up), .flush(flush),
      .o_left(o_left), .o_up(o_up), .o_finish_diag(o_finish_diag),
      .o_tile_done(o_tile_done), .o_busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vector layout: {in_ready(before edge), tile_done, finish_diag, up, left}
   logic [VW-1:0] exp_vec [MAXC];
   logic [VW-1:0] act_vec [MAXC];
   int            res_hist [MAXC][N][N];
   int            pe_acc [N][N];
   int            pe_res [N][N];
   int            tile_acc [N][N];
   logic [CW-1:0] exp_c [$];
   logic [CW-1:0] got_c [$];
   logic          m_fp;
   logic          m_open;
   int            m_k;
   int            cyc;
   int            checks;
   int            errors;

   function automatic int lane(input logic [NL-1:0] v, input int i);
      return int'(v[i*DW +: DW]);
   endfunction

   function automatic logic [NL-1:0] rnd_vec();
      logic [NL-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
      return v;
   endfunction

   // Reference: what one clock edge issues, and where it must show up in time.
   task automatic model_edge(input logic v, input logic [NL-1:0] l, input logic [NL-1:0] u,
                             input logic f, input logic r);
      int e = cyc;
      logic fin = 1'b0, clo = 1'b0, beat = 1'b0;
      logic [NL-1:0] dl = '0, du = '0;
      logic [CW-1:0] p;
      if (!r) begin
         for (int c = e; c <= e + 2*N; c++) exp_vec[c] = '0;
         m_fp = 1'b0; m_open = 1'b0; m_k = 0;
         exp_c.delete(); got_c.delete();
      end else begin
         if (m_fp) begin
            fin = 1'b1; clo = m_open; m_k = 0; m_open = 1'b0; m_fp = 1'b0;
         end else begin
            if (v) begin
               beat = 1'b1; dl = l; du = u;
               fin = (m_k == 0); clo = fin && m_open;
               m_k = (m_k + 1) % K; m_open = 1'b1;
            end
            if (f) m_fp = 1'b1;
         end
         for (int i = 0; i < N; i++) begin
            exp_vec[e+i][i*DW +: DW]      = dl[i*DW +: DW];
            exp_vec[e+i][NL+i*DW +: DW]   = du[i*DW +: DW];
         end
         for (int d = 0; d < ND; d++) exp_vec[e+d][2*NL+d] = fin;
         exp_vec[e+2*N-1][2*NL+ND] = clo;
         if (clo) begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) p[(i*N+j)*32 +: 32] = tile_acc[i][j];
            exp_c.push_back(p);
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (fin) tile_acc[i][j] = lane(dl, i) * lane(du, j);
               else if (beat) tile_acc[i][j] += lane(dl, i) * lane(du, j);
            end
      end
   endtask

   // One clock: drive, run the reference, sample the DUT, advance the PE-array model.
   task automatic tick(input logic v, input logic [NL-1:0] l, input logic [NL-1:0] u,
                       input logic f, input logic r);
      logic rdy_s, exp_r;
      logic [CW-1:0] g;
      in_valid = v; in_left = l; in_up = u; flush = f; rst_n = r;
      #1 rdy_s = in_ready;
      @(posedge clk);
      cyc++;
      exp_r = r && !m_fp;
      model_edge(v, l, u, f, r);
      exp_vec[cyc][VW-1] = exp_r;
      #1 act_vec[cyc] = {rdy_s, o_tile_done, o_finish_diag, o_up, o_left};
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int a, b;
            a = (cyc >= j) ? int'(act_vec[cyc-j][i*DW +: DW]) : 0;
            b = (cyc >= i) ? int'(act_vec[cyc-i][NL+j*DW +: DW]) : 0;
            if (act_vec[cyc][2*NL+i+j] === 1'b1) begin
               pe_res[i][j] = pe_acc[i][j];
               pe_acc[i][j] = a * b;
            end else begin
               pe_acc[i][j] += a * b;
            end
            res_hist[cyc][i][j] = pe_res[i][j];
         end
      if (act_vec[cyc][2*NL+ND] === 1'b1) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               g[(i*N+j)*32 +: 32] = res_hist[cyc-(2*N-1)+i+j][i][j];
         got_c.push_back(g);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      int t0, e, dn;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({o_left, o_up, o_finish_diag, o_tile_done, o_busy} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h expected 0", {o_left, o_up, o_finish_diag, o_tile_done, o_busy});
      end
      idle(1);
      t0 = cyc + 1;
      for (int k = 0; k < 3; k++) tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({o_left, o_up, o_finish_diag, o_tile_done, o_busy} !== '0) begin
         errors++; $display("FAIL midstream_reset got %h expected 0", {o_left, o_up, o_finish_diag, o_tile_done, o_busy});
      end
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      e = cyc;
      idle(2*N + 2);
      checks++;
      if (act_vec[e][2*NL] !== 1'b1) begin
         errors++; $display("FAIL reset_first_finish got %b expected 1", act_vec[e][2*NL]);
      end
      dn = 0;
      for (int c = e; c <= cyc; c++) if (act_vec[c][2*NL+ND] === 1'b1) dn++;
      checks++;
      if (dn != 0) begin errors++; $display("FAIL reset_no_done got %0d expected 0", dn); end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL reset_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
   endtask

   task automatic test_skew();
      int t0, e;
      logic [NL-1:0] l, u;
      logic [ND-1:0] oh;
      logic [DW-1:0] xl;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      for (int i = 0; i < N; i++) begin
         l[i*DW +: DW] = DW'(i + 1);
         u[i*DW +: DW] = DW'(i + 5);
      end
      tick(1'b1, l, u, 1'b0, 1'b1);
      e = cyc;
      checks++;
      if (o_busy !== 1'b1) begin errors++; $display("FAIL skew_busy got %b expected 1", o_busy); end
      idle(2*N + 2);
      for (int i = 0; i < N; i++)
         for (int c = e - 1; c <= e + N; c++) begin
            xl = (c == e + i) ? DW'(i + 1) : '0;
            checks++;
            if (act_vec[c][i*DW +: DW] !== xl) begin
               errors++; $display("FAIL skew_left lane %0d cycle %0d got %0d expected %0d", i, c - e, act_vec[c][i*DW +: DW], xl);
            end
            xl = (c == e + i) ? DW'(i + 5) : '0;
            checks++;
            if (act_vec[c][NL+i*DW +: DW] !== xl) begin
               errors++; $display("FAIL skew_up lane %0d cycle %0d got %0d expected %0d", i, c - e, act_vec[c][NL+i*DW +: DW], xl);
            end
         end
      for (int d = 0; d < ND; d++) begin
         oh = '0; oh[d] = 1'b1;
         checks++;
         if (act_vec[e+d][2*NL +: ND] !== oh) begin
            errors++; $display("FAIL skew_finish diag %0d got %b expected %b", d, act_vec[e+d][2*NL +: ND], oh);
         end
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL skew_idle_busy got %b expected 0", o_busy); end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL skew_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
   endtask

   task automatic test_full_tile();
      int t0, e, lows;
      logic [NL-1:0] la [K];
      logic [NL-1:0] ua [K];
      logic [CW-1:0] xc, g;
      int s;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      for (int k = 0; k < K; k++) begin
         la[k] = rnd_vec(); ua[k] = rnd_vec();
         tick(1'b1, la[k], ua[k], 1'b0, 1'b1);
      end
      tick(1'b0, '0, '0, 1'b1, 1'b1);
      e = cyc + 1;
      idle(2*N + 2);
      lows = 0;
      for (int c = t0; c <= cyc; c++) if (act_vec[c][VW-1] === 1'b0) lows++;
      checks++;
      if (lows != 1 || act_vec[e][VW-1] !== 1'b0) begin
         errors++; $display("FAIL full_ready_drop got %0d low cycles expected 1", lows);
      end
      checks++;
      if (act_vec[e+ND-1][2*NL+ND-1] !== 1'b1) begin
         errors++; $display("FAIL full_last_diag got %b expected 1", act_vec[e+ND-1][2*NL+ND-1]);
      end
      checks++;
      if ({act_vec[e+2*N][2*NL+ND], act_vec[e+2*N-1][2*NL+ND], act_vec[e+2*N-2][2*NL+ND]} !== 3'b010) begin
         errors++; $display("FAIL full_done_timing got %b expected 010",
            {act_vec[e+2*N][2*NL+ND], act_vec[e+2*N-1][2*NL+ND], act_vec[e+2*N-2][2*NL+ND]});
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < K; k++) s += lane(la[k], i) * lane(ua[k], j);
            xc[(i*N+j)*32 +: 32] = s;
         end
      checks++;
      if (got_c.size() != 1) begin
         errors++; $display("FAIL full_tile_count got %0d expected 1", got_c.size());
      end else begin
         g = got_c.pop_front();
         checks++;
         if (g !== xc) begin errors++; $display("FAIL full_tile_product got %h expected %h", g, xc); end
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy got %b expected 0", o_busy); end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL full_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
      got_c.delete(); exp_c.delete();
   endtask

   task automatic test_back_to_back();
      int t0, f, lows, dn, d0, d1;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      for (int k = 0; k < 2*K; k++) tick(1'b1, rnd_vec(), rnd_vec(), (k == 2*K - 1), 1'b1);
      f = cyc;
      idle(2*N + 3);
      lows = 0; dn = 0; d0 = 0; d1 = 0;
      for (int c = t0; c <= cyc; c++) begin
         if (act_vec[c][VW-1] === 1'b0) lows++;
         if (act_vec[c][2*NL+ND] === 1'b1) begin
            if (dn == 0) d0 = c; else d1 = c;
            dn++;
         end
      end
      checks++;
      if (lows != 1 || act_vec[f+1][VW-1] !== 1'b0) begin
         errors++; $display("FAIL b2b_ready got %0d low cycles expected 1 after flush", lows);
      end
      checks++;
      if (dn != 2 || d1 - d0 != K) begin
         errors++; $display("FAIL b2b_done got %0d pulses spacing %0d expected 2 pulses spacing %0d", dn, d1 - d0, K);
      end
      checks++;
      if (got_c.size() != exp_c.size()) begin
         errors++; $display("FAIL b2b_tile_count got %0d expected %0d", got_c.size(), exp_c.size());
      end
      while (got_c.size() > 0 && exp_c.size() > 0) begin
         logic [CW-1:0] g, x;
         g = got_c.pop_front(); x = exp_c.pop_front();
         checks++;
         if (g !== x) begin errors++; $display("FAIL b2b_tile_product got %h expected %h", g, x); end
      end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL b2b_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
      got_c.delete(); exp_c.delete();
   endtask

   task automatic test_short_tile();
      int t0, dn, e1, e2;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      tick(1'b0, '0, '0, 1'b1, 1'b1);
      idle(2*N + 2);
      dn = 0;
      for (int c = t0; c <= cyc; c++) if (act_vec[c][2*NL+ND] === 1'b1) dn++;
      checks++;
      if (dn != 1) begin errors++; $display("FAIL short_done got %0d pulses expected 1", dn); end
      checks++;
      if (got_c.size() != exp_c.size() || got_c.size() != 1) begin
         errors++; $display("FAIL short_tile_count got %0d expected 1", got_c.size());
      end
      while (got_c.size() > 0 && exp_c.size() > 0) begin
         logic [CW-1:0] g, x;
         g = got_c.pop_front(); x = exp_c.pop_front();
         checks++;
         if (g !== x) begin errors++; $display("FAIL short_tile_product got %h expected %h", g, x); end
      end
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      e1 = cyc;
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      e2 = cyc;
      idle(2*N + 2);
      checks++;
      if ({act_vec[e1][2*NL], act_vec[e2][2*NL]} !== 2'b10) begin
         errors++; $display("FAIL short_restart got %b expected 10", {act_vec[e1][2*NL], act_vec[e2][2*NL]});
      end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL short_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
      got_c.delete(); exp_c.delete();
   endtask

   task automatic test_flush_collision();
      int t0, e0, dn;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b1);
      e0 = cyc;
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b1, 1'b1);
      tick(1'b1, rnd_vec(), rnd_vec(), 1'b1, 1'b1);
      idle(2*N + 2);
      checks++;
      if ({act_vec[e0][2*NL], act_vec[e0+1][2*NL], act_vec[e0+2][2*NL], act_vec[e0+3][2*NL]} !== 4'b1010) begin
         errors++; $display("FAIL collide_finish got %b expected 1010",
            {act_vec[e0][2*NL], act_vec[e0+1][2*NL], act_vec[e0+2][2*NL], act_vec[e0+3][2*NL]});
      end
      checks++;
      if (act_vec[e0+1][N*DW-DW +: DW] === 8'hxx || act_vec[e0+2][VW-1] !== 1'b0) begin
         errors++; $display("FAIL collide_ready got %b expected 0", act_vec[e0+2][VW-1]);
      end
      dn = 0;
      for (int c = t0; c <= cyc; c++) if (act_vec[c][2*NL+ND] === 1'b1) dn++;
      checks++;
      if (dn != 1) begin errors++; $display("FAIL collide_done got %0d pulses expected 1", dn); end
      while (got_c.size() > 0 && exp_c.size() > 0) begin
         logic [CW-1:0] g, x;
         g = got_c.pop_front(); x = exp_c.pop_front();
         checks++;
         if (g !== x) begin errors++; $display("FAIL collide_tile_product got %h expected %h", g, x); end
      end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL collide_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
      got_c.delete(); exp_c.delete();
   endtask

   task automatic test_random();
      int t0;
      tick(1'b0, '0, '0, 1'b0, 1'b0);
      idle(1);
      t0 = cyc + 1;
      for (int k = 0; k < 300; k++)
         tick($urandom_range(0, 9) < 7, rnd_vec(), rnd_vec(), $urandom_range(0, 99) < 8, 1'b1);
      tick(1'b0, '0, '0, 1'b1, 1'b1);
      idle(2*N + 3);
      checks++;
      if (got_c.size() != exp_c.size()) begin
         errors++; $display("FAIL random_tile_count got %0d expected %0d", got_c.size(), exp_c.size());
      end
      while (got_c.size() > 0 && exp_c.size() > 0) begin
         logic [CW-1:0] g, x;
         g = got_c.pop_front(); x = exp_c.pop_front();
         checks++;
         if (g !== x) begin errors++; $display("FAIL random_tile_product got %h expected %h", g, x); end
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL random_idle_busy got %b expected 0", o_busy); end
      for (int c = t0; c <= cyc; c++) begin
         checks++;
         if (act_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL random_timeline cycle %0d got %h expected %h", c, act_vec[c], exp_vec[c]);
         end
      end
      got_c.delete(); exp_c.delete();
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      m_fp = 1'b0; m_open = 1'b0; m_k = 0;
      for (int c = 0; c < MAXC; c++) begin exp_vec[c] = '0; act_vec[c] = '0; end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            pe_acc[i][j] = 0; pe_res[i][j] = 0; tile_acc[i][j] = 0;
         end
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_left = '0; in_up = '0;
      test_reset();
      test_skew();
      test_full_tile();
      test_back_to_back();
      test_short_tile();
      test_flush_collision();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
